// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator with optional return-address stack.
//
// Produces the fetch PC each cycle: sequential advance by INC, absolute or
// PC-relative redirects, and (optionally) call/return through a small
// circular return-address stack. Any next PC that leaves the instruction
// memory window halts the block until reset.
//
// Configuration macro: PC_GEN_RAS_EN -- when defined, the return-address
// stack is built; otherwise i_call/i_ret are ignored, o_ras_empty=1 and
// o_ras_err=0.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      synchronous active-low reset
//   i_en         advance enable (0 = stall)
//   i_redir      redirect request
//   i_redir_abs  1 = absolute target, 0 = PC-relative signed offset
//   i_redir_val  target address or two's-complement offset
//   i_call       push PC+INC when a redirect is taken
//   i_ret        pop stack top into PC
//   o_pc         current PC
//   o_pc_valid   o_pc is fetchable (RUN state)
//   o_overflow   sticky out-of-range flag (block halted)
//   o_ras_empty  stack holds no entries
//   o_ras_err    one-cycle pulse on return from an empty stack
module pc_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int IMEM_AW    = 12,
  parameter int INC        = 4,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_redir,
  input  logic                  i_redir_abs,
  input  logic [ADDR_WIDTH-1:0] i_redir_val,
  input  logic                  i_call,
  input  logic                  i_ret,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_pc_valid,
  output logic                  o_overflow,
  output logic                  o_ras_empty,
  output logic                  o_ras_err
);

  localparam int AWX = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] pc_r, pc_nxt_s;
  logic                  valid_r, overflow_r, overflow_nxt_s;
  logic                  ras_err_r, ras_err_nxt_s;
  logic                  adv_s;

  // Candidate next-PC values, one extra bit to catch carry/borrow.
  logic [ADDR_WIDTH:0]   seq_sum_s, rel_sum_s, abs_sum_s, cand_s;
  logic                  oor_s;

  // Stack view shared with the next-PC selection.
  logic                  ret_act_s, ret_hit_s, ret_miss_s;
  logic [ADDR_WIDTH-1:0] ras_top_s;

  assign seq_sum_s = {1'b0, pc_r} + AWX'(INC);
  // Sign-extending the offset makes bit ADDR_WIDTH flag both carry and borrow.
  assign rel_sum_s = {1'b0, pc_r} + {i_redir_val[ADDR_WIDTH-1], i_redir_val};
  assign abs_sum_s = {1'b0, i_redir_val};

`ifdef PC_GEN_RAS_EN
  localparam int SPW  = $clog2(RAS_DEPTH);
  localparam int CNTW = SPW + 1;

  logic [ADDR_WIDTH-1:0] ras_r [RAS_DEPTH];
  logic [SPW-1:0]        sp_r;       // next write slot; top is sp_r-1
  logic [CNTW-1:0]       cnt_r;      // live entries, saturates at RAS_DEPTH
  logic [SPW-1:0]        top_idx_s;

  assign top_idx_s  = sp_r - SPW'(1);
  assign ras_top_s  = ras_r[top_idx_s];
  assign ret_act_s  = i_ret;
  assign ret_hit_s  = i_ret & (cnt_r != CNTW'(0));
  assign ret_miss_s = i_ret & (cnt_r == CNTW'(0));
  assign o_ras_empty = (cnt_r == CNTW'(0));

  // Stack pointer and occupancy; the circular pointer makes a full push
  // overwrite the oldest entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sp_r  <= '0;
      cnt_r <= '0;
    end else if (adv_s) begin
      if (ret_hit_s && !i_call) begin
        sp_r  <= top_idx_s;
        cnt_r <= cnt_r - CNTW'(1);
      end else if (!ret_act_s && i_redir && i_call) begin
        sp_r <= sp_r + SPW'(1);
        if (cnt_r != CNTW'(RAS_DEPTH)) begin
          cnt_r <= cnt_r + CNTW'(1);
        end
      end
    end
  end

  // Stack storage; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && adv_s) begin
      if (ret_hit_s && i_call) begin
        ras_r[top_idx_s] <= seq_sum_s[ADDR_WIDTH-1:0];
      end else if (!ret_act_s && i_redir && i_call) begin
        ras_r[sp_r] <= seq_sum_s[ADDR_WIDTH-1:0];
      end
    end
  end
`else
  logic unused_s;
  assign unused_s    = i_call ^ i_ret;
  assign ret_act_s   = 1'b0;
  assign ret_hit_s   = 1'b0;
  assign ret_miss_s  = 1'b0;
  assign ras_top_s   = '0;
  assign o_ras_empty = 1'b1;
`endif

  // Next-PC selection: return, then redirect, then sequential.
  always_comb begin
    cand_s = seq_sum_s;
    if (ret_hit_s) begin
      cand_s = {1'b0, ras_top_s};
    end else if (ret_act_s) begin
      cand_s = seq_sum_s;
    end else if (i_redir) begin
      cand_s = i_redir_abs ? abs_sum_s : rel_sum_s;
    end else begin
      cand_s = seq_sum_s;
    end
  end

  assign oor_s = |cand_s[ADDR_WIDTH:IMEM_AW];

  // Control FSM: next state, next PC and flag updates.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    overflow_nxt_s = overflow_r;
    ras_err_nxt_s  = 1'b0;
    adv_s          = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
        pc_nxt_s    = '0;
      end
      ST_RUN: begin
        if (i_en) begin
          ras_err_nxt_s = ret_miss_s;
          if (oor_s) begin
            state_nxt_s    = ST_HALT;
            overflow_nxt_s = 1'b1;
          end else begin
            pc_nxt_s = cand_s[ADDR_WIDTH-1:0];
            adv_s    = 1'b1;
          end
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s    = ST_BOOT;
        pc_nxt_s       = '0;
        overflow_nxt_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= ST_BOOT;
      pc_r       <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      ras_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      valid_r    <= (state_nxt_s == ST_RUN);
      overflow_r <= overflow_nxt_s;
      ras_err_r  <= ras_err_nxt_s;
    end
  end

  assign o_pc       = pc_r;
  assign o_pc_valid = valid_r;
  assign o_overflow = overflow_r;
  assign o_ras_err  = ras_err_r;

endmodule
